seq_add_multiplier: RTL and testbench

//   Sequential signed multiplier using repeated addition, one add per clock.

---
 rtl/seq_add_multiplier_pkg.sv | 13 +
 rtl/seq_add_multiplier_if.sv | 34 +++
 rtl/seq_add_multiplier_adder.sv | 16 +
 rtl/seq_add_multiplier.sv | 94 +++++++++
 tb/tb_seq_add_multiplier.sv | 138 +++++++++++++
 5 files changed

// File: rtl/seq_add_multiplier_pkg.sv
// Shared definitions for the repeated-addition signed multiplier:
// FSM state encoding and the default operand width.
package seq_add_multiplier_pkg;

    localparam int DEFAULT_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        FIX  = 2'd2
    } state_t;

endpackage

// File: rtl/seq_add_multiplier_if.sv
// Request/result bundle for the sequential multiplier. The requester drives
// start with the two signed operands; the multiplier returns the product with
// a one-cycle done pulse and reports busy while an operation is in flight.
interface seq_add_multiplier_if
    import seq_add_multiplier_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);
    logic                 start;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic [2*WIDTH-1:0]   p;
    logic                 done;
    logic                 busy;

    modport master (
        output start,
        output a,
        output b,
        input  p,
        input  done,
        input  busy
    );

    modport slave (
        input  start,
        input  a,
        input  b,
        output p,
        output done,
        output busy
    );

endinterface

// File: rtl/seq_add_multiplier_adder.sv
// Combinational N-bit adder, the additive counterpart of the subtractor used
// by the repeated-subtraction divider. Carry out is discarded (wrap arithmetic).
module seq_add_multiplier_adder #(
    parameter int N = 8
) (
    input  logic [N-1:0] x,
    input  logic [N-1:0] y,
    output logic [N-1:0] sum
);

    // Plain wrap-around sum; signedness is irrelevant in two's complement.
    always_comb begin
        sum = x + y;
    end

endmodule

// File: rtl/seq_add_multiplier.sv
// Sequential signed multiplier by repeated addition, one add per clock.
// The multiplicand is accumulated |b| times and the sign of b is applied once
// at the end, so a negative multiplicand simply accumulates negative values.
module seq_add_multiplier
    import seq_add_multiplier_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                clk,
    input  logic                reset,
    seq_add_multiplier_if.slave bus
);

    localparam logic [WIDTH:0] CNT_ONE = {{WIDTH{1'b0}}, 1'b1};

    state_t               state;
    logic [2*WIDTH-1:0]   acc;
    logic [2*WIDTH-1:0]   mcand;
    logic [WIDTH:0]       cnt;
    logic                 neg;
    logic [2*WIDTH-1:0]   p_q;
    logic                 done_q;

    logic [2*WIDTH-1:0]   a_ext;
    logic [WIDTH:0]       b_ext;
    logic [WIDTH:0]       b_abs;
    logic [2*WIDTH-1:0]   sum;

    // Operand preparation: sign-extend a to product width, and take |b| in
    // WIDTH+1 bits so the most negative multiplier still yields a valid count.
    always_comb begin
        a_ext = {{WIDTH{bus.a[WIDTH-1]}}, bus.a};
        b_ext = {bus.b[WIDTH-1], bus.b};
        b_abs = b_ext[WIDTH] ? -b_ext : b_ext;
    end

    seq_add_multiplier_adder #(
        .N (2*WIDTH)
    ) u_adder (
        .x   (acc),
        .y   (mcand),
        .sum (sum)
    );

    // Control FSM with registered product and done; reset aborts any operation.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            acc    <= '0;
            mcand  <= '0;
            cnt    <= '0;
            neg    <= 1'b0;
            p_q    <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus.start) begin
                        mcand <= a_ext;
                        cnt   <= b_abs;
                        neg   <= bus.b[WIDTH-1];
                        acc   <= '0;
                        state <= ADD;
                    end
                end
                ADD: begin
                    if (cnt != '0) begin
                        acc <= sum;
                        cnt <= cnt - CNT_ONE;
                    end else begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    p_q    <= neg ? -acc : acc;
                    done_q <= 1'b1;
                    state  <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Busy is decoded from state so it drops in the same cycle done rises.
    always_comb begin
        bus.busy = (state == ADD) || (state == FIX);
        bus.p    = p_q;
        bus.done = done_q;
    end

endmodule

// File: tb/tb_seq_add_multiplier.sv
// Directed bench for the repeated-addition multiplier: latency, product,
// back-to-back starts, async abort and ignored starts while busy.
module tb_seq_add_multiplier;

    localparam int WIDTH = 4;

    logic clk;
    logic reset;
    int   checks;
    int   failures;

    seq_add_multiplier_if #(.WIDTH(WIDTH)) bus ();

    seq_add_multiplier #(
        .WIDTH (WIDTH)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [15:0] actual,
                               input logic [15:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", tag, actual, expected);
        end
    endtask

    // Present a request before the next edge; returns #1 after the sampling edge.
    task automatic applyStimulus(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv);
        bus.start = 1'b1;
        bus.a     = av;
        bus.b     = bv;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    // Count edges since the start edge until done, bounded; then check result.
    task automatic waitDone(input string tag, input int already, input int expLat,
                            input logic [2*WIDTH-1:0] expP);
        int cycles;
        cycles = already;
        while (bus.done !== 1'b1 && cycles < 40) begin
            @(posedge clk);
            #1;
            cycles++;
        end
        checkOutput({tag, "_latency"}, 16'(cycles), 16'(expLat));
        checkOutput({tag, "_p"}, 16'(bus.p), 16'(expP));
        checkOutput({tag, "_busy_in_done"}, 16'(bus.busy), 16'h0);
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        reset     = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_p", 16'(bus.p), 16'h0);
        checkOutput("reset_done", 16'(bus.done), 16'h0);
        checkOutput("reset_busy", 16'(bus.busy), 16'h0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        // 5 * -2 = -10
        applyStimulus(4'sd5, -4'sd2);
        checkOutput("t1_busy_after_start", 16'(bus.busy), 16'h1);
        waitDone("t1", 0, 4, 8'hF6);
        @(posedge clk);
        #1;
        checkOutput("t1_done_one_cycle", 16'(bus.done), 16'h0);
        checkOutput("t1_p_holds", 16'(bus.p), 16'hF6);

        // -7 * 5 = -35
        applyStimulus(-4'sd7, 4'sd5);
        waitDone("t2", 0, 7, 8'hDD);

        // -8 * -8 = 64, largest count and largest magnitude product
        applyStimulus(-4'sd8, -4'sd8);
        waitDone("t3", 0, 10, 8'h40);

        // b = 0, then back-to-back starts issued in each done cycle
        applyStimulus(4'sd7, 4'sd0);
        waitDone("t4a", 0, 2, 8'h00);
        applyStimulus(4'sd0, 4'sd3);
        waitDone("t4b", 0, 5, 8'h00);
        applyStimulus(4'sd3, -4'sd3);
        waitDone("t4c", 0, 5, 8'hF7);

        // Async reset mid-operation aborts and clears p
        @(negedge clk);
        applyStimulus(4'sd6, 4'sd3);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        checkOutput("t5_abort_p", 16'(bus.p), 16'h0);
        checkOutput("t5_abort_done", 16'(bus.done), 16'h0);
        checkOutput("t5_abort_busy", 16'(bus.busy), 16'h0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        applyStimulus(4'sd6, 4'sd3);
        waitDone("t5_restart", 0, 5, 8'h12);

        // -6 * -4 = 24; start pulse with new operands while busy is ignored
        applyStimulus(-4'sd6, -4'sd4);
        @(posedge clk);
        #1;
        bus.start = 1'b1;
        bus.a     = 4'sd1;
        bus.b     = 4'sd1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        waitDone("t6", 2, 6, 8'h18);
        @(posedge clk);
        #1;
        checkOutput("t6_no_extra_done", 16'(bus.done), 16'h0);
        checkOutput("t6_idle_after", 16'(bus.busy), 16'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
